// File: rtl/cva6_pma_region_table_if.sv
// Lookup channel of the PMA region table: request (address) and registered
// response (hit / matching index / attributes) with valid/ready on both sides.
interface cva6_pma_region_table_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_hit;
    logic [IdxW-1:0]      rsp_idx;
    logic [2:0]           rsp_attr;

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_attr
    );

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_attr
    );
endinterface

// File: rtl/cva6_pma_region_table.sv
// Runtime-programmable physical-memory-attribute table: reset-loaded {base,len,attr,lock}
// entries, a config write port, and one registered address lookup per cycle.
module cva6_pma_region_table #(
    parameter int unsigned                   NrRules     = 8,
    parameter int unsigned                   AddrWidth   = 64,
    parameter logic [NrRules*AddrWidth-1:0]  RstBase     = (NrRules*AddrWidth)'(64'h0000_0000_8000_0000),
    parameter logic [NrRules*AddrWidth-1:0]  RstLen      = (NrRules*AddrWidth)'(64'h0000_0000_4000_0000),
    parameter logic [NrRules*3-1:0]          RstAttr     = (NrRules*3)'(3'b011),
    parameter logic [2:0]                    DefaultAttr = 3'b100,
    localparam int unsigned                  IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [2:0]           cfg_attr_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    cva6_pma_region_table_if.slave lkp
);

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [2:0]           attr_q [NrRules];
    logic [NrRules-1:0]   lock_q;
    logic                 cfg_err_q;

    logic                 wr_ok_s;
    logic [NrRules-1:0]   match_s;
    logic                 hit_s;
    logic [IdxW-1:0]      idx_s;
    logic [2:0]           attr_s;
    logic                 accept_s;

    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q,   rsp_hit_d;
    logic [IdxW-1:0]      rsp_idx_q,   rsp_idx_d;
    logic [2:0]           rsp_attr_q,  rsp_attr_d;

    // Config write is accepted only for an in-range, unlocked entry
    always_comb begin
        wr_ok_s = 1'b0;
        if (cfg_we_i && (32'(cfg_idx_i) < NrRules)) begin
            wr_ok_s = ~lock_q[cfg_idx_i];
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Table storage; locks are sticky until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLen[i*AddrWidth +: AddrWidth];
                attr_q[i] <= RstAttr[i*3 +: 3];
            end
            lock_q <= '0;
        end else if (wr_ok_s) begin
            base_q[cfg_idx_i] <= cfg_base_i;
            len_q[cfg_idx_i]  <= cfg_len_i;
            attr_q[cfg_idx_i] <= cfg_attr_i;
            lock_q[cfg_idx_i] <= lock_q[cfg_idx_i] | cfg_lock_i;
        end
    end

    // Rejection flag, a single-cycle pulse after the offending write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i & ~wr_ok_s;
        end
    end

    // Offset compare (addr-base < len) avoids base+len overflow at the top of the space
    always_comb begin
        match_s = '0;
        for (int i = 0; i < int'(NrRules); i++) begin
            match_s[i] = (len_q[i] != '0) && (lkp.req_addr >= base_q[i]) &&
                         ((lkp.req_addr - base_q[i]) < len_q[i]);
        end
    end

    // Lowest matching index wins: scan downwards so lower entries overwrite higher ones
    always_comb begin
        hit_s  = 1'b0;
        idx_s  = '0;
        attr_s = DefaultAttr;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            hit_s  = match_s[i] ? 1'b1       : hit_s;
            idx_s  = match_s[i] ? IdxW'(i)   : idx_s;
            attr_s = match_s[i] ? attr_q[i]  : attr_s;
        end
    end

    assign lkp.req_ready = ~rsp_valid_q | lkp.rsp_ready;
    assign accept_s      = lkp.req_valid & lkp.req_ready;

    // Response next state: load on accept, drop after consumption, otherwise hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_attr_d  = rsp_attr_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = hit_s;
            rsp_idx_d   = idx_s;
            rsp_attr_d  = attr_s;
        end else if (lkp.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_attr_q  <= DefaultAttr;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_attr_q  <= rsp_attr_d;
        end
    end

    assign lkp.rsp_valid = rsp_valid_q;
    assign lkp.rsp_hit   = rsp_hit_q;
    assign lkp.rsp_idx   = rsp_idx_q;
    assign lkp.rsp_attr  = rsp_attr_q;
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_cva6_pma_region_table.sv
// Scoreboard bench for cva6_pma_region_table: drivers push expected responses,
// an independent monitor pops and compares on every response handshake.
module tb_cva6_pma_region_table;

    localparam int unsigned NR   = 6;
    localparam int unsigned AW   = 64;
    localparam int unsigned IW   = 3;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [2:0] attr;
    } rsp_t;

    logic          clk;
    logic          rst_ni;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic [2:0]    cfg_attr;
    logic          cfg_lock;
    logic          cfg_err;

    int   n_checks = 0;
    int   n_bad    = 0;
    rsp_t exp_q [$];

    cva6_pma_region_table_if #(.AddrWidth(AW), .IdxW(IW)) bus ();

    cva6_pma_region_table #(.NrRules(NR), .AddrWidth(AW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_base_i (cfg_base),
        .cfg_len_i  (cfg_len),
        .cfg_attr_i (cfg_attr),
        .cfg_lock_i (cfg_lock),
        .cfg_err_o  (cfg_err),
        .lkp        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one comparison per response handshake
    always @(negedge clk) begin
        if (rst_ni === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            rsp_t e;
            rsp_t g;
            g = {bus.rsp_hit, bus.rsp_idx, bus.rsp_attr};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got hit=%0b idx=%0d attr=%03b expected no response",
                         g.hit, g.idx, g.attr);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL rsp: got hit=%0b idx=%0d attr=%03b expected hit=%0b idx=%0d attr=%03b",
                             g.hit, g.idx, g.attr, e.hit, e.idx, e.attr);
                end
            end
        end
    end

    task automatic lookup(input logic [63:0] addr, input logic h, input logic [2:0] idx,
                          input logic [2:0] attr);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                exp_q.push_back(rsp_t'({h, idx, attr}));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_bad++;
            $display("FAIL req_accept: got no accept within 50 cycles expected accept, addr=%0h", addr);
        end
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [63:0] base,
                             input logic [63:0] len, input logic [2:0] attr,
                             input logic lock, input logic exp_err);
        cfg_idx  = idx;
        cfg_base = base;
        cfg_len  = len;
        cfg_attr = attr;
        cfg_lock = lock;
        cfg_we   = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_err", 64'(cfg_err), 64'(exp_err));
        @(negedge clk);
        chk("cfg_err_pulse_end", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_hit",   64'(bus.rsp_hit),   64'd0);
        chk("rst_rsp_idx",   64'(bus.rsp_idx),   64'd0);
        chk("rst_rsp_attr",  64'(bus.rsp_attr),  64'(3'b100));
        chk("rst_cfg_err",   64'(cfg_err),       64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni        = 1'b1;
        cfg_we        = 1'b0;
        cfg_idx       = '0;
        cfg_base      = '0;
        cfg_len       = '0;
        cfg_attr      = '0;
        cfg_lock      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        #1;
        do_reset();

        // T1: reset table contents
        lookup(64'h0000_0000_8000_1000, 1'b1, 3'd0, 3'b011);
        lookup(64'h0000_0000_0001_0000, 1'b0, 3'd0, 3'b100);
        drain();

        // T2: write idx1 together with a lookup that must see the old table
        cfg_idx       = 3'd1;
        cfg_base      = 64'h0000_0000_0001_0000;
        cfg_len       = 64'h0000_0000_0001_0000;
        cfg_attr      = 3'b010;
        cfg_lock      = 1'b0;
        cfg_we        = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h0000_0000_0001_0000;
        @(negedge clk);
        chk("same_cycle_req_ready", 64'(bus.req_ready), 64'd1);
        exp_q.push_back(rsp_t'({1'b0, 3'd0, 3'b100}));
        @(posedge clk);
        #1;
        cfg_we        = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t2_cfg_err", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
        lookup(64'h0000_0000_0001_FFFF, 1'b1, 3'd1, 3'b010);
        lookup(64'h0000_0000_0002_0000, 1'b0, 3'd0, 3'b100);
        lookup(64'h0000_0000_0001_0000, 1'b1, 3'd1, 3'b010);
        lookup(64'h0000_0000_0000_FFFF, 1'b0, 3'd0, 3'b100);
        drain();

        // T4: overlap, lowest index wins
        cfg_write(3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_1000, 3'b100, 1'b0, 1'b0);
        lookup(64'h0000_0000_8000_0000, 1'b1, 3'd0, 3'b011);
        lookup(64'h0000_0000_BFFF_FFFF, 1'b1, 3'd0, 3'b011);
        lookup(64'h0000_0000_C000_0000, 1'b0, 3'd0, 3'b100);
        drain();

        // T5: region at the very top of the address space
        cfg_write(3'd4, 64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0000_2000, 3'b001, 1'b0, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 3'd4, 3'b001);
        lookup(64'h0000_0000_0000_0000, 1'b0, 3'd0, 3'b100);
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'd0, 3'b100);
        drain();

        // T6: back-to-back stream with a 3-cycle response stall
        fork
            begin
                lookup(64'h0000_0000_8000_0010, 1'b1, 3'd0, 3'b011);
                lookup(64'h0000_0000_0001_8000, 1'b1, 3'd1, 3'b010);
                lookup(64'hFFFF_FFFF_FFFF_F000, 1'b1, 3'd4, 3'b001);
                lookup(64'h0000_0000_0000_0005, 1'b0, 3'd0, 3'b100);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.rsp_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
                    chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                    chk("stall_rsp_held",  64'({bus.rsp_hit, bus.rsp_idx, bus.rsp_attr}),
                        64'({1'b1, 3'd1, 3'b010}));
                end
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
            end
        join
        drain();

        // T3: locking and out-of-range index
        cfg_write(3'd2, 64'h0000_0000_0003_0000, 64'h0000_0000_0000_0100, 3'b001, 1'b1, 1'b0);
        cfg_write(3'd2, 64'h0000_0000_0003_0000, 64'h0000_0000_0000_0100, 3'b010, 1'b0, 1'b1);
        lookup(64'h0000_0000_0003_0010, 1'b1, 3'd2, 3'b001);
        drain();
        cfg_write(3'(NR), 64'h0000_0000_0000_0000, 64'h0000_0000_0000_1000, 3'b011, 1'b0, 1'b1);
        do_reset();
        lookup(64'h0000_0000_0003_0010, 1'b0, 3'd0, 3'b100);
        lookup(64'h0000_0000_0001_0000, 1'b0, 3'd0, 3'b100);
        drain();
        cfg_write(3'd2, 64'h0000_0000_0003_0000, 64'h0000_0000_0000_0100, 3'b110, 1'b0, 1'b0);
        lookup(64'h0000_0000_0003_0010, 1'b1, 3'd2, 3'b110);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
